// File: rtl/satd_pkg.sv
// rtl/satd_pkg.sv - shared widths and FSM state type for the vertical SATD stage
package satd_pkg;

    // Signed coefficient width delivered by the horizontal row stage.
    function automatic int in_w(input int length);
        return length + 4;
    endfunction

    // Signed width of a vertical Hadamard result.
    function automatic int vw(input int length);
        return length + 7;
    endfunction

    // Unsigned width of the per-block SATD accumulator and output.
    function automatic int sum_w(input int length);
        return length + 12;
    endfunction

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/ht_vertical_col.sv
// rtl/ht_vertical_col.sv - combinational 8-point Hadamard over one buffered column
module ht_vertical_col
    import satd_pkg::*;
#(
    parameter int LENGTH = 8,
    localparam int IN_W = in_w(LENGTH),
    localparam int VW   = vw(LENGTH)
) (
    input  logic signed [IN_W-1:0] x [8],
    output logic signed [VW-1:0]   v [8]
);

    logic signed [VW-1:0] xe [8];
    logic signed [VW-1:0] a  [8];
    logic signed [VW-1:0] b  [8];

    // Sign-extend then run the three butterfly stages, pairing (0,4),(2,6),(1,5),(3,7) first
    // so the output set matches the horizontal stage's ordering.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            xe[i] = {{(VW-IN_W){x[i][IN_W-1]}}, x[i]};
        end

        a[0] = xe[0] + xe[4];
        a[1] = xe[0] - xe[4];
        a[2] = xe[2] + xe[6];
        a[3] = xe[2] - xe[6];
        a[4] = xe[1] + xe[5];
        a[5] = xe[1] - xe[5];
        a[6] = xe[3] + xe[7];
        a[7] = xe[3] - xe[7];

        b[0] = a[0] + a[2];
        b[1] = a[0] - a[2];
        b[2] = a[1] + a[3];
        b[3] = a[1] - a[3];
        b[4] = a[4] + a[6];
        b[5] = a[4] - a[6];
        b[6] = a[5] + a[7];
        b[7] = a[5] - a[7];

        v[0] = b[0] + b[4];
        v[1] = b[0] - b[4];
        v[2] = b[1] + b[5];
        v[3] = b[1] - b[5];
        v[4] = b[2] + b[6];
        v[5] = b[2] - b[6];
        v[6] = b[3] + b[7];
        v[7] = b[3] - b[7];
    end

endmodule

// File: rtl/ht_vertical_satd.sv
// rtl/ht_vertical_satd.sv - buffers an 8x8 block of row coefficients and emits its raw SATD
module ht_vertical_satd
    import satd_pkg::*;
#(
    parameter int LENGTH = 8,
    localparam int IN_W  = in_w(LENGTH),
    localparam int VW    = vw(LENGTH),
    localparam int SUM_W = sum_w(LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_row_0,
    input  logic signed [IN_W-1:0] in_row_1,
    input  logic signed [IN_W-1:0] in_row_2,
    input  logic signed [IN_W-1:0] in_row_3,
    input  logic signed [IN_W-1:0] in_row_4,
    input  logic signed [IN_W-1:0] in_row_5,
    input  logic signed [IN_W-1:0] in_row_6,
    input  logic signed [IN_W-1:0] in_row_7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_W-1:0]       satd
);

    // Eight |v| terms of up to 2^VW each need three extra bits.
    localparam int CS_W = VW + 4;

    state_t                 state;
    logic [2:0]             row_cnt;
    logic [2:0]             col_cnt;
    logic [SUM_W-1:0]       acc;
    logic [SUM_W-1:0]       acc_sum;

    logic signed [IN_W-1:0] in_row  [8];
    logic signed [IN_W-1:0] row_buf [8][8];
    logic signed [IN_W-1:0] col_in  [8];
    logic signed [VW-1:0]   col_v   [8];
    logic signed [VW:0]     col_ext [8];
    logic [VW:0]            mag     [8];
    logic [CS_W-1:0]        colsum;

    assign in_row[0] = in_row_0;
    assign in_row[1] = in_row_1;
    assign in_row[2] = in_row_2;
    assign in_row[3] = in_row_3;
    assign in_row[4] = in_row_4;
    assign in_row[5] = in_row_5;
    assign in_row[6] = in_row_6;
    assign in_row[7] = in_row_7;

    assign in_ready = (state == FILL) && !rst;

    // Row storage; every entry is rewritten before a drain reads it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            for (int c = 0; c < 8; c++) begin
                row_buf[row_cnt][c] <= in_row[c];
            end
        end
    end

    // Select the column currently being drained.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            col_in[r] = row_buf[r][col_cnt];
        end
    end

    ht_vertical_col #(
        .LENGTH (LENGTH)
    ) u_col (
        .x (col_in),
        .v (col_v)
    );

    // Absolute values taken one bit wider so the most negative result cannot wrap.
    always_comb begin
        colsum = '0;
        for (int k = 0; k < 8; k++) begin
            col_ext[k] = {col_v[k][VW-1], col_v[k]};
            mag[k]     = col_ext[k][VW] ? -col_ext[k] : col_ext[k];
            colsum     = colsum + CS_W'(mag[k]);
        end
    end

    assign acc_sum = acc + SUM_W'(colsum);

    // Block sequencing: fill 8 rows, drain 8 columns, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            row_cnt   <= '0;
            col_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            satd      <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (col_cnt == 3'd7) begin
                        satd      <= acc_sum;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        col_cnt   <= '0;
                        state     <= OUT;
                    end else begin
                        acc     <= acc_sum;
                        col_cnt <= col_cnt + 3'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ht_vertical_satd.sv
// tb/tb_ht_vertical_satd.sv - randomized self-checking bench for ht_vertical_satd
module tb_ht_vertical_satd;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] in_row [8];
    logic               out_valid;
    logic               out_ready;
    logic [19:0]        satd;

    int blk [8][8];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ht_vertical_satd #(
        .LENGTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row_0  (in_row[0]),
        .in_row_1  (in_row[1]),
        .in_row_2  (in_row[2]),
        .in_row_3  (in_row[3]),
        .in_row_4  (in_row[4]),
        .in_row_5  (in_row[5]),
        .in_row_6  (in_row[6]),
        .in_row_7  (in_row[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .satd      (satd)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: apply the 8x8 Sylvester Hadamard matrix H[k][r] = (-1)^popcount(k&r)
    // down each column and sum absolute values.
    function automatic longint ref_satd();
        longint total = 0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) begin
                longint s = 0;
                for (int r = 0; r < 8; r++) begin
                    if ($countones(k & r) % 2 == 1) s -= blk[r][c];
                    else                            s += blk[r][c];
                end
                total += (s < 0) ? -s : s;
            end
        end
        return total;
    endfunction

    task automatic fill_const(input int val);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = val;
    endtask

    task automatic fill_random(input int lim);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = int'($urandom_range(2 * lim, 0)) - lim;
    endtask

    task automatic drive_garbage();
        for (int c = 0; c < 8; c++) in_row[c] = 12'($urandom);
        in_valid = 1'($urandom);
    endtask

    // Present rows 0..n-1 of blk, one per accepted handshake.
    task automatic send_rows(input string tag, input int n);
        for (int r = 0; r < n; r++) begin
            int g = 0;
            @(negedge clk);
            for (int c = 0; c < 8; c++) in_row[c] = 12'(blk[r][c]);
            in_valid = 1'b1;
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) check({tag, " in_ready timeout"}, 0, 1);
            @(posedge clk);
        end
    endtask

    task automatic run_block(input string tag, input int bp, input longint exp);
        int lat = 0;
        send_rows(tag, 8);
        do begin
            @(negedge clk);
            drive_garbage();
            out_ready = 1'($urandom);
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 40);
        check({tag, " latency"}, lat, 8);
        check({tag, " satd"}, satd, exp);
        check({tag, " in_ready in OUT"}, in_ready, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive_garbage();
            @(posedge clk);
            #1;
            check({tag, " bp out_valid"}, out_valid, 1);
            check({tag, " bp satd"}, satd, exp);
            check({tag, " bp in_ready"}, in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " out_valid after accept"}, out_valid, 0);
        check({tag, " in_ready after accept"}, in_ready, 1);
        check({tag, " satd held"}, satd, exp);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " in_ready in reset"}, in_ready, 0);
        check({tag, " out_valid in reset"}, out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, " in_ready after reset"}, in_ready, 1);
        check({tag, " satd after reset"}, satd, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) in_row[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset satd", satd, 0);
        check("reset in_ready release", in_ready, 1);

        fill_const(0);
        run_block("zero", 0, 0);

        fill_const(0);
        blk[0][0] = 1;
        run_block("impulse", 0, 8);

        fill_const(1);
        run_block("ones", 0, 64);

        fill_const(-1);
        run_block("minus_ones", 1, 64);

        fill_const(2040);
        run_block("max", 0, 130560);

        fill_random(2040);
        run_block("backpressure", 10, ref_satd());

        fill_random(2040);
        send_rows("partial", 5);
        pulse_reset("rst_fill");
        fill_const(1);
        run_block("after_rst_fill", 0, 64);

        fill_random(2040);
        send_rows("drain_rst", 8);
        repeat (3) @(posedge clk);
        pulse_reset("rst_drain");
        fill_random(300);
        run_block("after_rst_drain", 2, ref_satd());

        for (int i = 0; i < 20; i++) begin
            fill_random((i % 2 == 0) ? 2040 : int'($urandom_range(255, 1)));
            run_block($sformatf("rand%0d", i), int'($urandom_range(3, 0)), ref_satd());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
